// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution window engine.
package conv_pkg;

  localparam int PIX_W  = 8;
  localparam int TAPS   = 9;
  localparam int PROD_W = 17;
  localparam int SUM_W  = 21;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic signed [7:0]        coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef coef_t [TAPS-1:0]         coef_arr_t;

  // Centre tap (c4) = 1, everything else 0: output equals the centre pixel.
  localparam coef_arr_t COEF_IDENTITY = coef_arr_t'(72'h00_0000_0001_0000_0000);

  function automatic pix_t clamp_u8(sum_t v);
    pix_t r;
    if (v[SUM_W-1])             r = '0;
    else if (|v[SUM_W-2:PIX_W]) r = '1;
    else                        r = v[PIX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// First-word fall-through output FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module conv_out_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/conv_window_engine.sv
// 3x3 signed MAC pipeline (products, sum, shift+clamp) feeding an output FIFO,
// with line-completion tagging and sticky overflow reporting.
module conv_window_engine
  import conv_pkg::*;
#(
  parameter int LINE_WIDTH = 512,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [71:0] i_pixel_data,
  input  logic        i_pixel_data_valid,
  input  logic [71:0] i_coef,
  input  logic [3:0]  i_shift,
  input  logic        i_coef_load,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  output logic        o_fifo_almost_full,
  output logic        o_overflow,
  output logic        o_line_done
);

  localparam int LCW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LCW-1:0] LINE_LAST = LCW'(LINE_WIDTH - 1);
  localparam logic [FCW-1:0] AF_LEVEL  = FCW'(FIFO_DEPTH - AF_MARGIN);

  coef_arr_t      coef_q;
  logic [3:0]     shift_q;
  logic [LCW-1:0] line_cnt_q;

  logic           s1_valid_q, s1_tag_q;
  logic [3:0]     s1_shift_q;
  prod_t          s1_prod_q [TAPS];
  prod_t          prod_d    [TAPS];

  logic           s2_valid_q, s2_tag_q;
  logic [3:0]     s2_shift_q;
  sum_t           s2_sum_q, sum_d, shifted;
  pix_t           result;

  logic           fifo_full, fifo_empty, wr_ok, pop_ok, drop;
  logic [FCW-1:0] fifo_count, count_d;
  logic           af_q, ovf_q, line_done_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      coef_q  <= COEF_IDENTITY;
      shift_q <= '0;
    end else if (i_coef_load) begin
      coef_q  <= coef_arr_t'(i_coef);
      shift_q <= i_shift;
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod_d[k] = prod_t'($signed({1'b0, i_pixel_data[8*k +: 8]})) * prod_t'(coef_t'(coef_q[k]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) sum_d = sum_d + sum_t'(s1_prod_q[k]);
  end

  // Shift travels with its window so a mid-stream load never splits one result.
  assign shifted = s2_sum_q >>> s2_shift_q;
  assign result  = clamp_u8(shifted);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      line_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= 1'b0;
    end else begin
      if (i_pixel_data_valid) line_cnt_q <= (line_cnt_q == LINE_LAST) ? '0 : line_cnt_q + LCW'(1);
      s1_valid_q <= i_pixel_data_valid;
      s1_tag_q   <= i_pixel_data_valid && (line_cnt_q == LINE_LAST);
      s2_valid_q <= s1_valid_q;
      s2_tag_q   <= s1_valid_q & s1_tag_q;
    end
  end

  always_ff @(posedge i_clk) begin
    s1_prod_q  <= prod_d;
    s1_shift_q <= shift_q;
    s2_sum_q   <= sum_d;
    s2_shift_q <= s1_shift_q;
  end

  conv_out_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (s2_valid_q),
    .data_i  (result),
    .pop_i   (i_data_ready),
    .data_o  (o_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pop_ok  = i_data_ready & ~fifo_empty;
  assign wr_ok   = s2_valid_q & (~fifo_full | pop_ok);
  assign drop    = s2_valid_q & fifo_full & ~pop_ok;
  assign count_d = fifo_count + FCW'(wr_ok) - FCW'(pop_ok);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      af_q        <= 1'b0;
      ovf_q       <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      af_q        <= (count_d >= AF_LEVEL);
      ovf_q       <= ovf_q | drop;
      line_done_q <= s2_valid_q & s2_tag_q;
    end
  end

  assign o_data_valid       = ~fifo_empty;
  assign o_fifo_almost_full = af_q;
  assign o_overflow         = ovf_q;
  assign o_line_done        = line_done_q;

endmodule

// File: doc/conv_window_engine.md
Name: conv_window_engine

Overview:
Consumer end of the 3x3 window stream produced by the line-buffer front end. It accepts one 72-bit window per valid cycle, and it never stalls the producer, which has no ready signal. Each window goes through a pipelined 9-tap signed multiply-accumulate, then shift, then clamp. The resulting 8-bit pixels are buffered in an output FIFO with a valid/ready handshake toward DMA/stream-out logic. The block also reports line completion and FIFO overflow.

Parameters:
LINE_WIDTH, 512, windows per image line; sets the o_line_done period.
FIFO_DEPTH, 16, output FIFO entries; power of two, at least 8.
AF_MARGIN, 4, almost-full asserts when occupancy >= FIFO_DEPTH-AF_MARGIN.

Ports:
i_clk  in  1  clock.
i_rst  in  1  reset; one clock, asynchronous, active-high.
i_pixel_data  in  72  window; tap k = bits [8k+7:8k], k=0..8, unsigned pixels; taps 0-2 are the oldest line.
i_pixel_data_valid  in  1  window present this cycle; always accepted.
i_coef  in  72  coefficients; c_k = bits [8k+7:8k], signed 8-bit.
i_shift  in  4  right-shift amount applied to the accumulator.
i_coef_load  in  1  latch i_coef and i_shift.
o_data  out  8  FIFO head pixel (first-word fall-through).
o_data_valid  out  1  FIFO not empty.
i_data_ready  in  1  downstream accepts; a pop occurs when o_data_valid & i_data_ready.
o_fifo_almost_full  out  1  occupancy >= FIFO_DEPTH-AF_MARGIN.
o_overflow  out  1  sticky: a result was dropped because the FIFO was full.
o_line_done  out  1  one-cycle pulse when the LINE_WIDTH-th result of a line reaches the FIFO stage.

Behaviour:
- Reset (asynchronous):
  - All outputs 0; FIFO empty; pipeline valids cleared; line counter 0.
  - Coefficient registers reset to identity: c4=1, all other taps 0, shift=0.
- Coefficient load:
  - i_coef_load at edge N updates the registers at edge N.
  - A window accepted at edge N uses the old set; windows from edge N+1 onward use the new set.
- Pipeline (fixed latency 3 edges, no stall):
  - Edge N, S1: window sampled with valid. Register 9 products: zero-extended pixel (9b signed) x c_k, giving 17b signed each.
  - Edge N+1, S2: register the 9-term sum, 21b signed; no overflow is possible.
  - Edge N+2, S3: arithmetic right shift by the shift register, then clamp to 0..255.
  - The S3 result is written to the FIFO at edge N+2. If the FIFO was empty, o_data_valid is high after edge N+2.
- FIFO:
  - Write when the S3 result is valid and (not full, or a pop occurs the same cycle). Full with a simultaneous pop counts as a successful write; no overflow.
  - Write attempted while full with no pop: the result is dropped and o_overflow sets; it clears only on reset.
  - Pop when empty is ignored.
  - Ordering is strict FIFO.
  - o_fifo_almost_full is a registered compare of the occupancy after the edge. The margin covers the 3 in-flight results plus 1, so the system uses it to stop feeding pixels.
- Line tracking:
  - An input window counter runs 0..LINE_WIDTH-1 and wraps.
  - The window at count LINE_WIDTH-1 carries a tag bit through S1-S3.
  - o_line_done pulses on the edge its result is written or dropped: exactly one pulse per LINE_WIDTH windows, regardless of FIFO state.
- Back-to-back windows: one result per cycle sustained; gaps in valid produce matching gaps in FIFO writes.

Decomposition:
- Package conv_pkg:
  - Constants PIX_W=8, TAPS=9, PROD_W=17, SUM_W=21.
  - Typedefs pix_t (logic [7:0]), coef_t (logic signed [7:0]), prod_t, sum_t, coef_arr_t (coef_t [8:0]).
  - Function clamp_u8(sum_t).
- One sub-module: conv_out_fifo.
  - Parameterised synchronous FWFT FIFO with push, pop, full, empty, count and async active-high reset.
  - conv_window_engine holds the MAC pipeline, coefficient registers and line counter.

Test Plan:
1. Reset, no load; window with p_k=k (p4=4), single valid -> o_data=4, o_data_valid rises after the 3rd edge; one entry only.
2. Load all c_k=1: shift=0 with all pixels 255 -> 255 (sum 2295 clamped); shift=4 -> 143; shift=3 -> 255.
3. Load c4=-8 and others 1; p4=200, others 0 -> 0 (clamp of -1600). Same coefficients with p4=0 and others 10 -> 80.
4. Coefficient load in the same cycle as window A, then window B next cycle -> A uses identity, B uses the new set.
5. i_data_ready=0; 20 consecutive windows (FIFO_DEPTH=16):
   - almost_full after the 12th write; o_overflow set on the 17th result.
   - With ready=1, exactly the first 16 results drain in order.
6. Two lines: 1024 windows -> two o_line_done pulses, each coinciding with the 512th/1024th result write. Then assert i_rst with 5 entries queued -> o_data_valid=0 immediately, and the identity kernel is restored.
